// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit:
// FSM states, queue entry layout and the default halt opcode.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] HALT_INSTR_DEF = 32'h0010_0073;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {data, pc} entries.
// Flush wins over push and pop; storage itself is never reset.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0] CNT_ONE = 1;
    localparam logic [PW:0] CNT_FULL = (PW+1)'(QDEPTH);

    fetch_entry_t mem [QDEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_ONE;
            if (pop) head_d = head_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail_q] <= wdata;
    end

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign head  = mem[head_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC register, IDLE/RUN/HALT FSM, sticky
// fault detection and redirect handling in front of fetch_queue.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          QDEPTH     = 4,
    parameter int unsigned IMEM_BYTES = 262144,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;

    logic         push;
    logic         pop;
    logic         q_full;
    logic         q_empty;
    logic         pc_bad;
    logic         is_halt;
    fetch_entry_t q_head;

    assign pc_bad  = (pc_q[1:0] != 2'b00) || (pc_q >= IMEM_LIMIT);
    assign is_halt = (imem_data == HALT_INSTR);
    assign pop     = !q_empty && inst_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        push    = 1'b0;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            fault_d = 1'b0;
            unique case (state_q)
                IDLE:    state_d = fetch_en ? RUN : IDLE;
                RUN:     state_d = fetch_en ? RUN : IDLE;
                HALT:    state_d = RUN;
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_en) state_d = RUN;
                end
                RUN: begin
                    push = !fault_q && !pc_bad && (!q_full || pop);
                    if (!fault_q && pc_bad) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else if (push && is_halt) begin
                        state_d = HALT;
                    end else if (!fetch_en) begin
                        state_d = IDLE;
                    end
                    // The halt word keeps the PC parked on its own address.
                    if (push && !is_halt) pc_d = pc_q + 32'd4;
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .flush(redirect_valid),
        .wdata('{data: imem_data, pc: pc_q}),
        .full (q_full),
        .empty(q_empty),
        .head (q_head)
    );

    assign imem_addr  = pc_q;
    assign inst_valid = !q_empty;
    assign inst_data  = q_head.data;
    assign inst_pc    = q_head.pc;
    assign halted     = (state_q == HALT);
    assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios push expected
// {pc, data} entries; a negedge monitor checks every handshake.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fault;

    logic [31:0] halt_addr;
    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    always_comb begin
        imem_data = (imem_addr == halt_addr) ? EBRK : NOP;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input logic [31:0] pc0, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{pc: pc0 + 32'(4 * i),
                           data: (pc0 + 32'(4 * i) == halt_addr) ? EBRK : NOP});
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        tick();
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_addr", imem_addr, 32'h0);
        sb.delete();
    endtask

    task automatic drain_check(input string name);
        repeat (6) tick();
        chk({name, "_drained"}, 32'(inst_valid), 0);
        chk({name, "_sb_left"}, 32'(sb.size()), 0);
        sb.delete();
    endtask

    // Monitor: every completed handshake must match the next expectation.
    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h, expected none",
                         inst_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pop_pc", inst_pc, e.pc);
                chk("pop_data", inst_data, e.data);
            end
        end
    end

    initial begin
        halt_addr = 32'hFFFF_FFFF;

        // Straight-line fetch of nops.
        do_reset();
        inst_ready = 1'b1;
        fetch_en   = 1'b1;
        expect_run(32'h0, 8);
        reset = 1'b0;
        repeat (8) tick();
        fetch_en = 1'b0;
        drain_check("seq");
        chk("seq_addr", imem_addr, 32'h20);

        // Backpressure: queue fills to depth, PC stalls.
        do_reset();
        fetch_en = 1'b1;
        expect_run(32'h0, 9);
        reset = 1'b0;
        repeat (10) tick();
        chk("bp_valid", 32'(inst_valid), 1);
        chk("bp_addr", imem_addr, 32'h10);
        chk("bp_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        repeat (4) tick();
        fetch_en = 1'b0;
        drain_check("bp");
        chk("bp_addr_end", imem_addr, 32'h24);

        // Redirect while full: same-cycle pop delivered, rest flushed.
        do_reset();
        fetch_en = 1'b1;
        reset = 1'b0;
        repeat (6) tick();
        sb.push_back('{pc: 32'h0, data: NOP});
        expect_run(32'h100, 3);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("rd_flush", 32'(inst_valid), 0);
        chk("rd_addr", imem_addr, 32'h100);
        tick();
        chk("rd_head", inst_pc, 32'h100);
        tick();
        fetch_en = 1'b0;
        drain_check("rd");

        // Halt instruction at 0x8.
        do_reset();
        halt_addr  = 32'h8;
        inst_ready = 1'b1;
        fetch_en   = 1'b1;
        expect_run(32'h0, 3);
        reset = 1'b0;
        repeat (4) tick();
        chk("halt_flag", 32'(halted), 1);
        chk("halt_addr", imem_addr, 32'h8);
        repeat (5) tick();
        chk("halt_frozen", imem_addr, 32'h8);
        chk("halt_sb_left", 32'(sb.size()), 0);
        chk("halt_idle_q", 32'(inst_valid), 0);

        // Misaligned then out-of-range redirects fault with no push.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        chk("mis_addr", imem_addr, 32'h102);
        chk("mis_fault_lag", 32'(fault), 0);
        tick();
        chk("mis_fault", 32'(fault), 1);
        chk("mis_halted", 32'(halted), 1);
        chk("mis_nopush", 32'(inst_valid), 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40000;
        tick();
        redirect_valid = 1'b0;
        chk("oob_clear", 32'(fault), 0);
        tick();
        chk("oob_fault", 32'(fault), 1);
        chk("oob_halted", 32'(halted), 1);
        chk("oob_nopush", 32'(inst_valid), 0);

        // Recovery redirect to 0 resumes fetching.
        halt_addr = 32'hFFFF_FFFF;
        expect_run(32'h0, 3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("rec_fault", 32'(fault), 0);
        chk("rec_halted", 32'(halted), 0);
        tick();
        tick();
        fetch_en = 1'b0;
        drain_check("rec");

        // Asynchronous reset with 3 entries queued.
        do_reset();
        fetch_en = 1'b1;
        reset = 1'b0;
        repeat (4) tick();
        chk("ar_pre_valid", 32'(inst_valid), 1);
        chk("ar_pre_addr", imem_addr, 32'hC);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", 32'(inst_valid), 0);
        chk("ar_addr", imem_addr, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_no_early", 32'(inst_valid), 0);
        tick();
        chk("ar_refetch", inst_pc, 32'h0);
        fetch_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset.
REQ-002 Parameter QDEPTH, default 4: fetch queue depth in entries; power of two, 2..16.
REQ-003 Parameter IMEM_BYTES, default 262144: instruction memory size; word addresses at or above IMEM_BYTES fault.
REQ-004 Parameter HALT_INSTR, default 32'h0010_0073 (ebreak): instruction word that stops fetch.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 fetch_en  in  1  level; permits leaving IDLE.
REQ-008 imem_addr  out  32  byte address to instruction memory; equals current PC.
REQ-009 imem_data  in  32  instruction word, combinationally valid for imem_addr in the same cycle.
REQ-010 inst_valid  out  1  queue head valid toward decode.
REQ-011 inst_ready  in  1  decode accepts head; pop when inst_valid && inst_ready.
REQ-012 inst_data  out  32  head instruction word.
REQ-013 inst_pc  out  32  head instruction byte address.
REQ-014 redirect_valid  in  1  one-cycle flush and PC load request.
REQ-015 redirect_pc  in  32  new PC, sampled when redirect_valid.
REQ-016 halted  out  1  high in HALT state.
REQ-017 fault  out  1  sticky; set on misaligned or out-of-bounds PC; cleared only by reset or a valid redirect.

Function
REQ-018 FSM states: IDLE, RUN, HALT. IDLE->RUN when fetch_en; RUN->HALT on pushing HALT_INSTR or on fault; RUN->IDLE when fetch_en falls; HALT->RUN or IDLE->RUN on a valid redirect (IDLE requires fetch_en).
REQ-019 Push condition: state RUN, !fault, no redirect this cycle, and (count<QDEPTH or pop this cycle); push writes {imem_data, PC} at tail and PC advances by 4 next cycle.
REQ-020 No push while the queue is full without a same-cycle pop; PC holds and imem_addr remains stable.
REQ-021 Latency: a word pushed in cycle N is visible at inst_valid/inst_data in cycle N+1; a redirect in cycle N yields imem_addr=redirect_pc in cycle N+1 and the first new entry at the head in N+2.
REQ-022 Redirect has priority over push and pop: flush sets count=0, clears fault, loads redirect_pc; any same-cycle handshake completes on the outputs but its data is not retained.
REQ-023 A redirect_pc with bits[1:0]!=0 or >=IMEM_BYTES is loaded, then sets fault in the following cycle with no push.
REQ-024 HALT_INSTR is pushed (decode receives it); no further pushes until a redirect; the queue keeps draining in HALT.
REQ-025 inst_valid = (count!=0); inst_data/inst_pc are don't-care when inst_valid is low; the head is stable while inst_valid && !inst_ready.
REQ-026 Head/tail pointers are log2(QDEPTH) bits, wrapping modulo QDEPTH; count is log2(QDEPTH)+1 bits; simultaneous push and pop leaves count unchanged.
REQ-027 PC arithmetic is 32-bit modulo 2^32; overflow is caught by the bounds check, not by wrap.
REQ-028 imem_addr is driven only from the PC register, never combinationally from redirect_pc.

Reset
REQ-029 On reset assertion: state=IDLE, PC=RESET_PC, count=0, pointers=0, fault=0; outputs inst_valid=0, halted=0, fault=0, imem_addr=RESET_PC.
REQ-030 Reset mid-operation discards all queued entries; the first push after release occurs no earlier than one cycle after fetch_en is seen high.
REQ-031 Queue storage array needs no reset; only valid tracking is reset.

Structure
REQ-032 Package fetch_pkg holds the state enum (IDLE/RUN/HALT), the fetch entry struct {data, pc}, and the default HALT_INSTR constant.
REQ-033 Sub-module fetch_queue: parameterised synchronous FIFO (push, pop, flush, full, empty, head) instantiated once; fetch_ctrl holds the FSM, PC, and fault logic.

Verification
REQ-034 Reset, fetch_en=1, inst_ready=1, memory holds 0x13 (nop) words -> inst_pc sequence 0x0,0x4,0x8,... one per cycle starting the cycle after the first push.
REQ-035 inst_ready=0 for 10 cycles -> exactly 4 entries queued, imem_addr holds 0x10, no entry lost or duplicated after inst_ready returns high.
REQ-036 redirect_valid with redirect_pc=0x100 while the queue is full and inst_ready=1 -> count 0 next cycle, imem_addr=0x100, next inst_pc=0x100.
REQ-037 Word 0x0010_0073 at 0x8 -> entries 0x0,0x4,0x8 delivered, halted=1, imem_addr frozen at 0x8, no pushes until redirect.
REQ-038 redirect_pc=0x102, then redirect_pc=0x40000 -> fault=1 each time, no push, halted=1; a later redirect to 0x0 clears fault and resumes.
REQ-039 Assert reset asynchronously mid-burst with 3 entries queued -> inst_valid=0 and imem_addr=RESET_PC before the next clk edge.
